// File: rtl/ripple_borrow_subtractor_serial_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor:
// FSM encoding, default operand width and counter sizing.
package ripple_borrow_subtractor_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ripple_borrow_subtractor_serial_fs.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module ripple_borrow_subtractor_serial_fs (
    input  logic x_i,
    input  logic y_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i ^ bi_i;
    assign bo_o = (~x_i & y_i) | (~x_i & bi_i) | (y_i & bi_i);

endmodule

// File: rtl/ripple_borrow_subtractor_serial.sv
// Bit-serial subtractor: one full-subtractor cell reused over WIDTH cycles,
// LSB first, with the borrow carried between bits in a flip-flop.
module ripple_borrow_subtractor_serial
    import ripple_borrow_subtractor_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               done_q;
    logic               ready_q;

    logic               bit_d;
    logic               borrow_d;
    logic [WIDTH-1:0]   res_d;

    ripple_borrow_subtractor_serial_fs fs_inst (
        .x_i  (a_q[0]),
        .y_i  (b_q[0]),
        .bi_i (borrow_q),
        .d_o  (bit_d),
        .bo_o (borrow_d)
    );

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

    // Sequencing FSM, serial datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && ready_q) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_SUB;
                    end else begin
                        ready_q  <= 1'b1;
                    end
                end
                ST_SUB: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= borrow_d;
                    res_q    <= res_d;
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= res_d;
                        bout_q  <= borrow_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign done  = done_q;

endmodule

// File: tb/tb_ripple_borrow_subtractor_serial.sv
// Directed and random self-checking bench for the serial subtractor (WIDTH=8).
module tb_ripple_borrow_subtractor_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ripple_borrow_subtractor_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .diff  (diff),
        .bout  (bout),
        .done  (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: accept on the next edge, then walk edges 1..W+1.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cin, input logic [7:0] ed, input logic eb, input bit full);
        int dones;
        dones = 0;
        a = av; b = bv; bin = cin; start = 1'b1;
        tick();
        start = 1'b0; a = ~av; b = ~bv; bin = ~cin;
        if (full) check_eq({tag, ".ready_busy"}, 32'(ready), 32'd0);
        for (int e = 1; e <= W; e++) begin
            tick();
            if (done) dones++;
        end
        check_eq({tag, ".done_at_W"}, 32'(done), 32'd1);
        check_eq({tag, ".diff"}, 32'(diff), 32'(ed));
        check_eq({tag, ".bout"}, 32'(bout), 32'(eb));
        if (full) check_eq({tag, ".ready_at_W"}, 32'(ready), 32'd0);
        tick();
        if (done) dones++;
        check_eq({tag, ".done_count"}, 32'(dones), 32'd1);
        check_eq({tag, ".ready_back"}, 32'(ready), 32'd1);
        if (full) check_eq({tag, ".diff_hold"}, 32'(diff), 32'(ed));
    endtask

    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [7:0] vd [3];
    logic       ve [3];

    initial begin
        int         dones;
        logic [7:0] cur_diff;
        logic       cur_bout;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] rr;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #2;
        check_eq("rst.ready", 32'(ready), 32'd1);
        check_eq("rst.done",  32'(done),  32'd0);
        check_eq("rst.diff",  32'(diff),  32'd0);
        check_eq("rst.bout",  32'(bout),  32'd0);
        tick();
        tick();
        rst = 1'b0;

        run_op("op_5_3",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1);
        run_op("op_0_1",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1);
        run_op("op_80_7f",  8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);
        run_op("op_ff_ff",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);

        // start re-pulsed mid-operation with different operands must be ignored
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        tick();
        dones = 0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) dones++;
            if (e == 8) check_eq("repulse.diff_at_8", 32'(diff), 32'h02);
        end
        check_eq("repulse.done_count", 32'(dones), 32'd1);
        check_eq("repulse.diff_final", 32'(diff), 32'h02);

        // reset after edge 4 of an operation aborts it
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        rst = 1'b1;
        #1;
        check_eq("abort.ready", 32'(ready), 32'd1);
        check_eq("abort.done",  32'(done),  32'd0);
        check_eq("abort.diff",  32'(diff),  32'd0);
        check_eq("abort.bout",  32'(bout),  32'd0);
        dones = 0;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (done) dones++;
        end
        rst = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (done) dones++;
        end
        check_eq("abort.no_done", 32'(dones), 32'd0);
        run_op("abort.next", 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b1);

        // back-to-back with start held high: one accept every W+2 edges
        va[0] = 8'h5A; vb[0] = 8'h3C; vc[0] = 1'b0; vd[0] = 8'h1E; ve[0] = 1'b0;
        va[1] = 8'h12; vb[1] = 8'h34; vc[1] = 1'b1; vd[1] = 8'hDD; ve[1] = 1'b1;
        va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1; vd[2] = 8'hFF; ve[2] = 1'b1;
        cur_diff = 8'h0E;
        cur_bout = 1'b0;
        start = 1'b1;
        for (int e = 0; e < 30; e++) begin
            a = va[e / 10]; b = vb[e / 10]; bin = vc[e / 10];
            tick();
            if (e % 10 == 8) begin
                cur_diff = vd[e / 10];
                cur_bout = ve[e / 10];
            end
            check_eq($sformatf("b2b.done_e%0d", e),  32'(done),  32'(e % 10 == 8));
            check_eq($sformatf("b2b.diff_e%0d", e),  32'(diff),  32'(cur_diff));
            check_eq($sformatf("b2b.bout_e%0d", e),  32'(bout),  32'(cur_bout));
            check_eq($sformatf("b2b.ready_e%0d", e), 32'(ready), 32'(e % 10 == 9));
        end
        start = 1'b0;
        tick();
        check_eq("b2b.idle_after", 32'(ready), 32'd1);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rr = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
            run_op($sformatf("rand%0d", i), ra, rb, rc, rr[7:0], rr[8], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
